// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: accepts a WIDTH-bit word over valid/ready and shifts it out MSB first.
// Define SER_PARITY_EN to append an even-parity bit after bit 0 (frames become WIDTH+1 bits).
module piso_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] par_data_in,
    input  logic             par_valid_in,
    output logic             par_ready_out,
    output logic             serial_out,
    output logic             serial_valid_out,
    output logic             busy_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef SER_PARITY_EN
        SHIFT  = 2'd1,
        PARITY = 2'd2
`else
        SHIFT  = 2'd1
`endif
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sreg_reg, sreg_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               serial_out_reg, serial_out_next;
    logic               serial_valid_reg, serial_valid_next;
`ifdef SER_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    logic               last_bit;
    logic               ready_state;
    logic               transfer;

    assign last_bit = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

    // States in which a new word may be taken on the next enabled edge.
    always_comb begin
        ready_state = 1'b0;
        case (state_reg)
            IDLE:    ready_state = 1'b1;
`ifdef SER_PARITY_EN
            PARITY:  ready_state = 1'b1;
`else
            SHIFT:   ready_state = last_bit;
`endif
            default: ready_state = 1'b0;
        endcase
    end

    assign par_ready_out = clk_en & ~rst_in & ready_state;
    assign transfer      = par_valid_in & par_ready_out;
    assign busy_out      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
`ifdef SER_PARITY_EN
        parity_next = parity_reg;
`endif
        if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        state_next = SHIFT;
                        sreg_next  = par_data_in;
                        cnt_next   = '0;
`ifdef SER_PARITY_EN
                        parity_next = ^par_data_in;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_reg == CNT_LAST) begin
                        sreg_next = sreg_reg << 1;
                        cnt_next  = '0;
`ifdef SER_PARITY_EN
                        state_next = PARITY;
`else
                        if (transfer) begin
                            state_next = SHIFT;
                            sreg_next  = par_data_in;
                        end else begin
                            state_next = IDLE;
                        end
`endif
                    end else begin
                        sreg_next = sreg_reg << 1;
                        cnt_next  = cnt_reg + CNT_W'(1);
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    if (transfer) begin
                        state_next  = SHIFT;
                        sreg_next   = par_data_in;
                        cnt_next    = '0;
                        parity_next = ^par_data_in;
                    end else begin
                        state_next = IDLE;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output registers track the bit that the next state will present.
    always_comb begin
        serial_out_next   = 1'b0;
        serial_valid_next = 1'b0;
        case (state_next)
            SHIFT: begin
                serial_out_next   = sreg_next[WIDTH-1];
                serial_valid_next = 1'b1;
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                serial_out_next   = parity_next;
                serial_valid_next = 1'b1;
            end
`endif
            default: begin
                serial_out_next   = 1'b0;
                serial_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg        <= IDLE;
            sreg_reg         <= '0;
            cnt_reg          <= '0;
            serial_out_reg   <= 1'b0;
            serial_valid_reg <= 1'b0;
        end else if (clk_en) begin
            state_reg        <= state_next;
            sreg_reg         <= sreg_next;
            cnt_reg          <= cnt_next;
            serial_out_reg   <= serial_out_next;
            serial_valid_reg <= serial_valid_next;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            parity_reg <= 1'b0;
        end else if (clk_en) begin
            parity_reg <= parity_next;
        end
    end
`endif

    assign serial_out       = serial_out_reg;
    assign serial_valid_out = serial_valid_reg;

endmodule
